// File: rtl/register_8bit.sv
// ---------------------------------------------------------------------------
// register_8bit
//   Parameterised storage register with write enable and asynchronous
//   active-low reset. The output is driven straight from the flops, so there
//   is no combinational path from load/wdata to out.
//
// Ports
//   clk    in   1      single clock, rising-edge active
//   rstn   in   1      asynchronous reset, active-low
//   load   in   1      write enable, sampled on the clk rising edge
//   wdata  in   WIDTH  data stored when load is high
//   out    out  WIDTH  current stored value
// ---------------------------------------------------------------------------
module register_8bit #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] out
);

  // Reset is in the sensitivity list, so it wins over load on every edge and
  // forces out immediately; no write can be pending across reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out <= RESET_VALUE;
    end else if (load) begin
      out <= wdata;
    end
  end

endmodule

// File: tb/tb_register_8bit.sv
module tb_register_8bit;

  logic       clk;
  logic       rstn;
  logic       load;
  logic [7:0] wdata;
  logic [7:0] out;

  int checks;
  int fails;

  register_8bit dut (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load),
    .wdata (wdata),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, out=%h expected finish", out);
    $fatal(1, "watchdog");
  end

  // Drive inputs on the falling edge, away from the sampling edge.
  task automatic drive(input logic l, input logic [7:0] d);
    @(negedge clk);
    load  = l;
    wdata = d;
  endtask

  // Step past the next rising edge and settle before sampling.
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    load  = 1'b0;
    wdata = 8'h00;
    #1;
    checks++;
    if (out !== 8'h00) begin
      fails++;
      $display("FAIL reset_immediate: out=%h expected=%h", out, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00);
      edge_sample();
      checks++;
      if (out !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold[%0d]: out=%h expected=%h", i, out, 8'h00);
      end
    end
  endtask

  task automatic test_reset_over_load();
    drive(1'b1, 8'hAA);
    edge_sample();
    checks++;
    if (out !== 8'h00) begin
      fails++;
      $display("FAIL reset_over_load: out=%h expected=%h", out, 8'h00);
    end
  endtask

  task automatic test_load_sequence();
    logic [7:0] vals [6];
    logic [7:0] prev;
    vals = '{8'h55, 8'hA5, 8'h66, 8'h88, 8'hFF, 8'hCC};
    prev = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vals[i]);
      #1;
      checks++;
      if (out !== prev) begin
        fails++;
        $display("FAIL load_latency[%0d]: out=%h expected=%h", i, out, prev);
      end
      edge_sample();
      checks++;
      if (out !== vals[i]) begin
        fails++;
        $display("FAIL load_seq[%0d]: out=%h expected=%h", i, out, vals[i]);
      end
      prev = vals[i];
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 8'hA5);
    edge_sample();
    checks++;
    if (out !== 8'hA5) begin
      fails++;
      $display("FAIL hold_setup: out=%h expected=%h", out, 8'hA5);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h3C);
      edge_sample();
      checks++;
      if (out !== 8'hA5) begin
        fails++;
        $display("FAIL hold[%0d]: out=%h expected=%h", i, out, 8'hA5);
      end
    end
  endtask

  task automatic test_same_value();
    drive(1'b1, 8'hA5);
    edge_sample();
    checks++;
    if (out !== 8'hA5) begin
      fails++;
      $display("FAIL same_value_edge: out=%h expected=%h", out, 8'hA5);
    end
    #3;
    checks++;
    if (out !== 8'hA5) begin
      fails++;
      $display("FAIL same_value_mid: out=%h expected=%h", out, 8'hA5);
    end
  endtask

  task automatic test_bit_independence();
    logic [7:0] pats [6];
    pats = '{8'h01, 8'h80, 8'h7E, 8'h81, 8'h5A, 8'h00};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, pats[i]);
      edge_sample();
      checks++;
      if (out !== pats[i]) begin
        fails++;
        $display("FAIL bit_pattern[%0d]: out=%h expected=%h", i, out, pats[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'hFF);
    edge_sample();
    checks++;
    if (out !== 8'hFF) begin
      fails++;
      $display("FAIL async_setup: out=%h expected=%h", out, 8'hFF);
    end
    @(negedge clk);
    load = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (out !== 8'h00) begin
      fails++;
      $display("FAIL async_reset_immediate: out=%h expected=%h", out, 8'h00);
    end
    drive(1'b1, 8'h77);
    edge_sample();
    checks++;
    if (out !== 8'h00) begin
      fails++;
      $display("FAIL async_reset_load_blocked: out=%h expected=%h", out, 8'h00);
    end
    @(negedge clk);
    rstn = 1'b1;
    edge_sample();
    checks++;
    if (out !== 8'h77) begin
      fails++;
      $display("FAIL async_release_load: out=%h expected=%h", out, 8'h77);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_reset_over_load();
    test_load_sequence();
    test_hold();
    test_same_value();
    test_bit_independence();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/register_8bit.md
REGISTER_8BIT -- requirements
Module: register_8bit

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL expose parameter RESET_VALUE, default 0 (WIDTH bits), giving the value `out` takes during reset.
REQ-003 Port `clk`, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 Port `rstn`, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port `load`, input, 1 bit: write enable, active-high, sampled on the `clk` rising edge.
REQ-006 Port `wdata`, input, WIDTH bits: data to store when `load` is high.
REQ-007 Port `out`, output, WIDTH bits: current stored value, driven directly from the storage flops.
REQ-008 The block SHALL have exactly one clock and one reset, with no other ports.

Function
REQ-009 On a `clk` rising edge with `rstn`=1 and `load`=1, `out` SHALL take the value of `wdata` sampled at that edge.
REQ-010 On a `clk` rising edge with `rstn`=1 and `load`=0, `out` SHALL hold its previous value.
REQ-011 Write latency SHALL be one clock edge: new data is visible on `out` immediately after the loading edge, not before.
REQ-012 `out` SHALL NOT change between clock edges except through reset; there is no combinational path from `wdata` or `load` to `out`.
REQ-013 Back-to-back loads on consecutive edges SHALL each take effect, with no idle cycle required.
REQ-014 Loading the same value as currently stored SHALL leave `out` unchanged, with no glitch.
REQ-015 Each bit SHALL be stored independently, with no arithmetic, masking or width conversion.
REQ-016 If `load` or `wdata` is X/Z at a sampled edge, the stored value is not required to be meaningful; benches SHALL drive known values.

Reset
REQ-017 When `rstn` goes low, `out` SHALL take RESET_VALUE (8'h00 by default) immediately, independent of `clk`.
REQ-018 While `rstn` is low, `out` SHALL remain at RESET_VALUE regardless of `clk`, `load` and `wdata`.
REQ-019 Reset SHALL take priority over load on any edge where `rstn` is low.
REQ-020 After `rstn` deasserts, the first `clk` rising edge with `load`=1 SHALL store `wdata` normally.
REQ-021 Asserting reset in the middle of a sequence of loads SHALL discard the stored value, and no pending write SHALL survive the reset.

Verification
REQ-022 All benches SHALL drive stimulus on the `clk` falling edge to avoid races with the sampling edge.
REQ-023 Reset scenario: `rstn`=0, `load`=0, `wdata`=00 -> `out`=00 with no clock edge needed; `out` stays 00 through subsequent edges while `rstn`=0.
REQ-024 Load sequence scenario: release `rstn`, then `load`=1 with `wdata`=55, A5, 66, 88, FF, CC on consecutive cycles -> after each rising edge, `out` equals that cycle's `wdata` (55, A5, 66, 88, FF, CC).
REQ-025 Hold scenario: `out`=A5, then `load`=0 with `wdata`=3C for 3 edges -> `out` remains A5.
REQ-026 Async reset mid-operation scenario: `out`=FF, `rstn` pulled low between edges -> `out`=00 immediately; `load`=1, `wdata`=77 while in reset -> `out` stays 00; after release, next loading edge -> `out`=77.
REQ-027 Reset-over-load scenario: `rstn`=0 and `load`=1 with `wdata`=AA at the same rising edge -> `out`=00.
